// File: rtl/sram_arbiter.sv
// Single-port arbiter for the external asynchronous SRAM: display reads have priority,
// encoder writes are buffered and forced onto the bus after STARVE_LIMIT lost cycles.
module sram_arbiter #(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 16,
   parameter int WBUF_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_ack,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic              o_wr_idle,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq,
   output logic              o_sram_dq_oe,
   input  logic [DATA_W-1:0] i_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n
);

   localparam int PTR_W = $clog2(WBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t            state_r;
   state_t            state_nxt;
   logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
   logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [STV_W-1:0]  starve_cnt;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              forced;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(WBUF_DEPTH));
   assign o_wr_ready = !fifo_full;
   assign push       = i_wr_valid && !fifo_full;
   assign forced     = (starve_cnt == STV_W'(STARVE_LIMIT)) && !fifo_empty;
   assign pop        = (state_nxt == S_WRITE);
   assign o_wr_idle  = fifo_empty && (state_r != S_WRITE);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = S_IDLE;
      o_rd_ack  = 1'b0;
      if (forced) begin
         state_nxt = S_WRITE;
      end else if (i_rd_req) begin
         state_nxt = S_READ;
         o_rd_ack  = 1'b1;
      end else if (!fifo_empty) begin
         state_nxt = S_WRITE;
      end
   end

   // NOTE: FIFO storage has no reset; count guards every read, so stale entries are never used.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= i_wr_addr;
         fifo_data[wr_ptr] <= i_wr_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
         // Only reads that cost a pending write a slot count toward starvation.
         if (pop || fifo_empty)
            starve_cnt <= '0;
         else if (state_nxt == S_READ && starve_cnt != STV_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + STV_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= S_IDLE;
         o_sram_addr  <= '0;
         o_sram_dq    <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
         o_rd_valid   <= 1'b0;
         o_rd_data    <= '0;
      end else begin
         state_r    <= state_nxt;
         o_rd_valid <= (state_r == S_READ);
         if (state_r == S_READ) o_rd_data <= i_sram_dq;
         case (state_nxt)
            S_READ: begin
               o_sram_addr  <= i_rd_addr;
               o_sram_ce_n  <= 1'b0;
               o_sram_oe_n  <= 1'b0;
               o_sram_we_n  <= 1'b1;
               o_sram_dq_oe <= 1'b0;
            end
            S_WRITE: begin
               o_sram_addr  <= fifo_addr[rd_ptr];
               o_sram_dq    <= fifo_data[rd_ptr];
               o_sram_ce_n  <= 1'b0;
               o_sram_oe_n  <= 1'b1;
               o_sram_we_n  <= 1'b0;
               o_sram_dq_oe <= 1'b1;
            end
            default: begin
               o_sram_ce_n  <= 1'b1;
               o_sram_oe_n  <= 1'b1;
               o_sram_we_n  <= 1'b1;
               o_sram_dq_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port arbiter for the external asynchronous SRAM. It shares the SRAM between two requesters: the display read path, which has priority, and the frame encoder write stream, which is buffered. It sits between the frame encoder's SRAM write outputs, the VGA pixel fetcher and the top-level SRAM pins. All SRAM control and data outputs are registered, and read latency is fixed.

## Interface
- ADDR_W, 20 (= sram_pkg::SRAM_ADDR_COUNT), SRAM address width
- DATA_W, 16 (= sram_pkg::SRAM_DATA_WIDTH), SRAM data width
- WBUF_DEPTH, 4, write FIFO depth, power of two ≥ 2
- STARVE_LIMIT, 8, consecutive read-won cycles with writes pending before a write is forced, ≥ 1

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rd_req  in  1  display read request; held until acked
- i_rd_addr  in  ADDR_W  read address
- o_rd_ack  out  1  combinational: read accepted this cycle
- o_rd_data  out  DATA_W  read data, valid when o_rd_valid
- o_rd_valid  out  1  registered read-data strobe
- i_wr_valid  in  1  encoder write valid
- i_wr_addr  in  ADDR_W  write address
- i_wr_data  in  DATA_W  write data
- o_wr_ready  out  1  FIFO not full
- o_wr_idle  out  1  FIFO empty and no write on bus
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_dq  out  DATA_W  write data to pad
- o_sram_dq_oe  out  1  pad tristate enable, 1 = drive
- i_sram_dq  in  DATA_W  data from pad
- o_sram_ce_n / o_sram_oe_n / o_sram_we_n  out  1 each  SRAM strobes, active low

## Operation
- FSM state_r names the bus operation in the current cycle: S_IDLE, S_READ, S_WRITE.
- Next-state decision, in priority order:
  - Forced write: starve_cnt == STARVE_LIMIT and FIFO non-empty → S_WRITE. Pop the FIFO. o_rd_ack = 0.
  - Otherwise i_rd_req → S_READ. o_rd_ack = 1. Latch i_rd_addr into o_sram_addr.
  - Otherwise FIFO non-empty → S_WRITE. Pop the FIFO. Latch the head entry into addr/dq.
  - Otherwise → S_IDLE.
- Registered pin values per next state:
  - S_IDLE: ce_n = 1, oe_n = 1, we_n = 1, dq_oe = 0. Addr and dq hold.
  - S_READ: ce_n = 0, oe_n = 0, we_n = 1, dq_oe = 0.
  - S_WRITE: ce_n = 0, oe_n = 1, we_n = 0, dq_oe = 1.
- starve_cnt behaviour:
  - Increments when S_READ is chosen while the FIFO is non-empty.
  - Clears when S_WRITE is chosen, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Write FIFO:
  - Push on i_wr_valid && o_wr_ready. o_wr_ready = !full, derived from registered count only.
  - No bypass: an entry is poppable the cycle after its push.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo WBUF_DEPTH. Count width is clog2(WBUF_DEPTH)+1.
- o_wr_idle = (count == 0) && state_r != S_WRITE. The frame scheduler uses it to confirm a frame is committed.

## Timing
- Read path:
  - Ack in cycle t → pins show the read in cycle t+1.
  - i_sram_dq is captured at the end of t+1.
  - o_rd_valid = 1 with o_rd_data in cycle t+2, for one cycle.
  - Latency is always exactly 2 cycles.
- Write path: pop in cycle t → we_n low for exactly cycle t+1.
- Earliest write after push: push at edge e → pop decided in the next cycle → we_n low one cycle after that.
- Back-to-back operations in any order are allowed, with no dead cycles.
- A read request in a forced-write cycle is acked in the following cycle. The requester holds i_rd_req and i_rd_addr until acked.
- Reset (asynchronous):
  - state_r = S_IDLE, FIFO empty, starve_cnt = 0.
  - o_sram_addr = 0, o_sram_dq = 0, o_sram_dq_oe = 0, ce_n/oe_n/we_n = 1.
  - o_rd_valid = 0, o_rd_data = 0, o_wr_ready = 1, o_wr_idle = 1.
- Reset mid-write drops all FIFO contents and any in-flight read result. No partial strobe persists after reset assertion.

## Test plan
- Single read: i_rd_req with addr 0x00123 and SRAM model returning 0xBEEF. Expect o_rd_ack in the same cycle, oe_n low one cycle later, and o_rd_valid with 0xBEEF 2 cycles after ack.
- Write burst: 4 writes (0x10→0xA0 … 0x13→0xA3) on consecutive cycles with no reads. Expect o_wr_ready to stay 1 and 4 consecutive we_n-low cycles in order. o_wr_idle returns to 1 the cycle after the last write.
- FIFO full: i_rd_req held high, 5 writes offered. Expect o_wr_ready to drop after the 4th push and the 5th write to be held by the source.
- Starvation: continuous i_rd_req with the FIFO non-empty. Expect 8 reads, then exactly one forced write with o_rd_ack = 0 in that cycle, then reads resume. Repeat until the FIFO drains.
- Interleaved pattern: reads every other cycle plus a write stream. Expect alternating READ/WRITE with no idle cycles and no read delayed.
- Reset: assert i_rst_n low during a write cycle with 3 entries queued. Expect pins at reset values immediately, o_wr_idle = 1, and no further we_n pulses after release.
